// File: rtl/main_mem_pkg.sv
// Shared constants, state encoding and request payload for the main-memory responder.
package main_mem_pkg;

    localparam int unsigned LINE_BITS     = 128;
    localparam int unsigned ADDR_BITS     = 10;
    localparam int unsigned WORD_OFF_BITS = 4;
    localparam int unsigned LINE_IDX_BITS = ADDR_BITS - WORD_OFF_BITS;
    localparam int unsigned CNT_BITS      = 4;
    localparam int unsigned STAT_BITS     = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mm_state_t;

    // Request fields captured at accept time.
    typedef struct packed {
        logic                     write;
        logic [LINE_IDX_BITS-1:0] line;
        logic [LINE_BITS-1:0]     wdata;
    } mm_req_t;

    // Byte address to line index; the word/byte offset is dropped.
    function automatic logic [LINE_IDX_BITS-1:0] lineIndex(input logic [ADDR_BITS-1:0] addr);
        return addr[ADDR_BITS-1:WORD_OFF_BITS];
    endfunction

endpackage

// File: rtl/main_mem_array.sv
// Single-port line-wide storage: synchronous write, registered read, no reset.
module main_mem_array
    import main_mem_pkg::*;
#(
    parameter int unsigned DEPTH_LINES = 64
) (
    input  logic                     clk,
    input  logic [LINE_IDX_BITS-1:0] addr,
    input  logic                     we,
    input  logic [LINE_BITS-1:0]     wdata,
    output logic [LINE_BITS-1:0]     rdata
);

    logic [LINE_BITS-1:0] mem [DEPTH_LINES];

    // Read returns the pre-write contents when read and write hit the same line.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/main_mem_responder.sv
// Multi-cycle line read/write responder for the cache-to-memory interface.
// Optional MAIN_MEM_STATS_EN adds read/write response counters (rd_count, wr_count).
module main_mem_responder
    import main_mem_pkg::*;
#(
    parameter int unsigned LATENCY     = 4,
    parameter int unsigned DEPTH_LINES = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [LINE_BITS-1:0] req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 resp_write,
    output logic [LINE_BITS-1:0] resp_rdata
`ifdef MAIN_MEM_STATS_EN
    ,
    output logic [STAT_BITS-1:0] rd_count,
    output logic [STAT_BITS-1:0] wr_count
`endif
);

    if (LATENCY < 1 || LATENCY > 15) begin : gLatencyCheck
        $fatal(1, "main_mem_responder: LATENCY %0d outside 1..15", LATENCY);
    end

    mm_state_t                state;
    mm_state_t                stateNext;
    logic [CNT_BITS-1:0]      cnt;
    mm_req_t                  reqQ;
    logic                     accept;
    logic                     lastBusy;
    logic                     reqReadyNext;
    logic                     respValidNext;
    logic                     arrWe;
    logic [LINE_IDX_BITS-1:0] arrAddr;
    logic [LINE_BITS-1:0]     arrRdata;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (req_valid && req_ready)    stateNext = BUSY;
            BUSY: if (cnt == '0)                  stateNext = RESP;
            RESP: if (resp_valid && resp_ready)   stateNext = IDLE;
            default:                              stateNext = IDLE;
        endcase
    end

    // Output decode. The array is addressed from the request bus in IDLE so
    // the line is already sitting in the read register by the first BUSY cycle.
    always_comb begin
        accept        = 1'b0;
        lastBusy      = 1'b0;
        arrWe         = 1'b0;
        arrAddr       = reqQ.line;
        reqReadyNext  = (stateNext == IDLE);
        respValidNext = (stateNext == RESP);
        case (state)
            IDLE: begin
                accept  = req_valid && req_ready;
                arrAddr = lineIndex(req_addr);
            end
            BUSY: begin
                lastBusy = (cnt == '0);
                arrWe    = lastBusy && reqQ.write && rst_n;
            end
            default: ;
        endcase
    end

    main_mem_array #(
        .DEPTH_LINES(DEPTH_LINES)
    ) uArray (
        .clk  (clk),
        .addr (arrAddr),
        .we   (arrWe),
        .wdata(reqQ.wdata),
        .rdata(arrRdata)
    );

    // Request latch, latency counter and registered response outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_write <= 1'b0;
            resp_rdata <= '0;
            cnt        <= '0;
            reqQ       <= '0;
        end else begin
            req_ready  <= reqReadyNext;
            resp_valid <= respValidNext;
            if (accept) begin
                reqQ.write <= req_write;
                reqQ.line  <= lineIndex(req_addr);
                reqQ.wdata <= req_wdata;
                cnt        <= CNT_BITS'(LATENCY - 1);
            end else if (state == BUSY) begin
                if (!lastBusy) begin
                    cnt <= cnt - CNT_BITS'(1);
                end else begin
                    resp_write <= reqQ.write;
                    resp_rdata <= reqQ.write ? reqQ.wdata : arrRdata;
                end
            end
        end
    end

`ifdef MAIN_MEM_STATS_EN
    // Counters advance on the response handshake only; free-running wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (resp_valid && resp_ready) begin
            if (resp_write) begin
                wr_count <= wr_count + STAT_BITS'(1);
            end else begin
                rd_count <= rd_count + STAT_BITS'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_main_mem_responder.sv
// Scoreboard bench for main_mem_responder: a line model predicts every response.
module tb_main_mem_responder;

`ifdef MAIN_MEM_TB_LAT1
    localparam int unsigned LAT = 1;
`else
    localparam int unsigned LAT = 4;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [9:0]   req_addr;
    logic [127:0] req_wdata;
    logic         resp_valid;
    logic         resp_ready;
    logic         resp_write;
    logic [127:0] resp_rdata;
`ifdef MAIN_MEM_STATS_EN
    logic [15:0]  rd_count;
    logic [15:0]  wr_count;
`endif

    always #5 clk = ~clk;

    main_mem_responder #(
        .LATENCY(LAT),
        .DEPTH_LINES(64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_write(resp_write),
        .resp_rdata(resp_rdata)
`ifdef MAIN_MEM_STATS_EN
        ,
        .rd_count  (rd_count),
        .wr_count  (wr_count)
`endif
    );

    typedef struct packed {
        logic         write;
        logic [127:0] data;
    } exp_t;

    exp_t         expQ[$];
    logic [127:0] model [64];
    int           nTests = 0;
    int           nFail  = 0;
    logic [15:0]  expRd  = '0;
    logic [15:0]  expWr  = '0;

    task automatic checkEq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Predict the response from the line model at the time the request is driven.
    task automatic pushExp(input logic wr, input logic [9:0] addr, input logic [127:0] data);
        exp_t e;
        logic [5:0] line;
        line = addr[9:4];
        if (wr) model[line] = data;
        e.write = wr;
        e.data  = model[line];
        expQ.push_back(e);
    endtask

    // Response monitor: the handshake completes on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            if (expQ.size() == 0) begin
                checkEq("unexpected_resp", 128'(1), 128'(0));
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkEq("resp_write", 128'(resp_write), 128'(e.write));
                checkEq("resp_rdata", resp_rdata, e.data);
                if (e.write) expWr = expWr + 16'(1);
                else         expRd = expRd + 16'(1);
            end
        end
    end

    // Issue one request and wait for the response to appear; checks ready drop and latency.
    task automatic sendReq(input logic wr, input logic [9:0] addr, input logic [127:0] data);
        int n;
        n = 0;
        while (!req_ready && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            checkEq("req_ready_timeout", 128'(req_ready), 128'(1));
            return;
        end
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = data;
        pushExp(wr, addr, data);
        @(posedge clk); #1;
        req_valid = 1'b0;
        checkEq("ready_drop", 128'(req_ready), 128'(0));
        n = 0;
        while (!resp_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checkEq("latency", 128'(n), 128'(LAT));
    endtask

    // Hold the response for a number of cycles, optionally pulse a request, then take it.
    task automatic respond(input int hold, input logic [127:0] expData, input logic pulse);
        for (int i = 0; i < hold; i++) begin
            checkEq("hold_valid", 128'(resp_valid), 128'(1));
            checkEq("hold_data", resp_rdata, expData);
            if (pulse && i == 1) begin
                req_valid = 1'b1;
                req_write = 1'b1;
                req_addr  = 10'h100;
                req_wdata = 128'hBAD;
            end
            @(posedge clk); #1;
            if (req_valid) begin
                req_valid = 1'b0;
                checkEq("no_accept_in_resp", 128'(req_ready), 128'(0));
            end
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        checkEq("valid_drop", 128'(resp_valid), 128'(0));
        checkEq("ready_back", 128'(req_ready), 128'(1));
    endtask

    localparam logic [127:0] W1 = 128'h4444_3333_2222_1111;
    localparam logic [127:0] P3F = 128'hA5A5_0F0F_1234_5678_9ABC_DEF0_CAFE_F00D;

    initial begin
        int k;
        logic [127:0] d;
`ifdef MAIN_MEM_STATS_EN
        logic [15:0] wrMark;
`endif
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkEq("rst_req_ready", 128'(req_ready), 128'(0));
        checkEq("rst_resp_valid", 128'(resp_valid), 128'(0));
        checkEq("rst_resp_write", 128'(resp_write), 128'(0));
        checkEq("rst_resp_rdata", resp_rdata, 128'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkEq("ready_after_reset", 128'(req_ready), 128'(1));

        // Write then read the same line with a different offset.
        sendReq(1'b1, 10'h040, W1);
        checkEq("wr_echo_write", 128'(resp_write), 128'(1));
        checkEq("wr_echo_data", resp_rdata, W1);
        respond(0, W1, 1'b0);
        sendReq(1'b0, 10'h04C, '0);
        checkEq("rd_write_flag", 128'(resp_write), 128'(0));
        respond(5, W1, 1'b1);

        // Several lines with random data, read back in reverse.
        for (int i = 0; i < 4; i++) begin
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            sendReq(1'b1, {6'(8 + i), 4'(i)}, d);
            respond(i % 2, d, 1'b0);
        end
        for (int i = 3; i >= 0; i--) begin
            d = model[6'(8 + i)];
            sendReq(1'b0, {6'(8 + i), 4'hF - 4'(i)}, '0);
            respond(1, d, 1'b0);
        end

        // Reset during BUSY of a write must leave the line untouched.
        sendReq(1'b1, 10'h3F0, P3F);
        respond(0, P3F, 1'b0);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 10'h3F8;
        req_wdata = 128'hDEAD;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n     = 1'b0;
        @(posedge clk); #1;
        checkEq("abort_resp_valid", 128'(resp_valid), 128'(0));
        checkEq("abort_req_ready", 128'(req_ready), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        sendReq(1'b0, 10'h3F4, '0);
        respond(0, P3F, 1'b0);

        // Back-to-back spacing with resp_ready held high.
        resp_ready = 1'b1;
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_addr   = 10'h200;
        req_wdata  = d;
        pushExp(1'b1, 10'h200, d);
        @(posedge clk); #1;
        req_write = 1'b0;
        req_addr  = 10'h204;
        pushExp(1'b0, 10'h204, '0);
        k = 0;
        while (!req_ready && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        checkEq("b2b_spacing", 128'(k + 1), 128'(LAT + 2));
        @(posedge clk); #1;
        req_valid = 1'b0;
        k = 0;
        while (expQ.size() != 0 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        resp_ready = 1'b0;
        checkEq("b2b_drained", 128'(expQ.size()), 128'(0));

`ifdef MAIN_MEM_STATS_EN
        checkEq("rd_count", 128'(rd_count), 128'(expRd));
        checkEq("wr_count", 128'(wr_count), 128'(expWr));
        force dut.wr_count = 16'hFFFF;
        @(posedge clk); #1;
        release dut.wr_count;
        wrMark = expWr;
        sendReq(1'b1, 10'h010, W1);
        respond(0, W1, 1'b0);
        checkEq("wr_count_wrap", 128'(wr_count), 128'(16'(16'hFFFF + 16'(expWr - wrMark))));
`endif

        k = 0;
        while (expQ.size() != 0 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        checkEq("queue_empty", 128'(expQ.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/main_mem_responder.md
# main_mem_responder

Clocked main-memory responder that sits on the memory side of the cache-to-memory block interface and serves whole 4-word (128-bit) line reads and writes. Accepts one request at a time via valid/ready, models a fixed access latency, and returns the line (or a write acknowledge) via a valid/ready response channel. Replaces the combinational main memory so cache controllers can be exercised against realistic multi-cycle miss and write-back timing.

## Interface
- `LATENCY`, 4: cycles from request accept to `resp_valid`; legal range 1..15.
- `DEPTH_LINES`, 64: number of 128-bit lines; 64 lines × 16 B = 1 KiB, matching the 10-bit byte address.
- `clk` in 1: the only clock; all logic on the rising edge.
- `rst_n` in 1: reset is synchronous and active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept a request.
- `req_write` in 1: 0 = line read, 1 = line write.
- `req_addr` in 10: byte address; `[9:4]` line index, `[3:0]` ignored.
- `req_wdata` in 128: write line; word 0 in `[31:0]`, word 3 in `[127:96]`.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: requester takes the response.
- `resp_write` out 1: echo of the latched `req_write`.
- `resp_rdata` out 128: read line; for writes, the data just written.

## Operation
- FSM states are IDLE, BUSY and RESP. Reset state is IDLE.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid && req_ready`, latch write flag, line index and wdata; load the counter with `LATENCY-1`; go to BUSY.
- BUSY:
  - `req_ready` = 0.
  - If counter ≠ 0, decrement it.
  - If counter = 0:
    - write: store the latched wdata into the line.
    - read: capture the line into the response register.
  - After that edge, go to RESP.
- RESP:
  - `resp_valid` = 1 and is held stable with its data until `resp_ready`.
  - On `resp_valid && resp_ready`, go to IDLE.
- Requests are never accepted in BUSY or RESP. `req_*` changes there are ignored.
- Read-after-write to the same line returns the new data, because the commit happens before RESP.
- Reset mid-operation (BUSY or RESP):
  - Return to IDLE; the pending response is dropped.
  - A write not yet committed (still in BUSY) is discarded and memory is unchanged.
  - Memory contents are never cleared by reset.
- Counter is 4 bits. The `LATENCY` range is checked at elaboration; an illegal value is a fatal error.

## Timing
- Reset values: `req_ready`=0 while `rst_n`=0, then 1 from the first cycle in IDLE. `resp_valid`=0, `resp_write`=0, `resp_rdata`=0.
- Request accepted at edge t → `resp_valid` high after edge t+LATENCY. With LATENCY=1, it is high in the cycle right after accept.
- Minimum request-to-request spacing is LATENCY+2 edges: one RESP cycle plus one IDLE cycle. There is no back-to-back accept in the cycle `resp_ready` is seen.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.

## Configuration
- `MAIN_MEM_STATS_EN` defined: adds outputs `rd_count` and `wr_count` (out, 16 bits each).
  - Each increments on a read / write response handshake.
  - Reset to 0; wrap from 16'hFFFF to 0.
  - A response dropped by reset is not counted.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Shared package `main_mem_pkg`:
  - constants `LINE_BITS=128`, `ADDR_BITS=10`, `WORD_OFF_BITS=4`;
  - state enum `mm_state_t` {IDLE, BUSY, RESP};
  - line-index slice helper.
- One natural sub-module: `main_mem_array`, a single-port line-wide storage with registered read and synchronous write, no reset. The FSM and counter stay in the top.

## Test plan
- Reset, then write line at addr 10'h040 with 128'h4444_3333_2222_1111 (LATENCY=4): `req_ready` drops the cycle after accept; `resp_valid` high exactly 4 edges after accept; `resp_write`=1; `resp_rdata` echoes the data.
- Read 10'h04C (same line, offset ignored): returns 128'h4444_3333_2222_1111 after 4 cycles.
- Hold `resp_ready`=0 for 5 cycles in RESP: `resp_valid` and `resp_rdata` stay stable; a `req_valid` pulse during that time is not accepted.
- Assert `rst_n`=0 during BUSY of a write of 128'hDEAD to line 0x3F, then read line 0x3F: returns the prior contents, and `resp_valid`=0 right after reset.
- LATENCY=1 build: accept at edge t, `resp_valid` at t+1; a second request is accepted at the earliest at t+3 with `resp_ready` held 1.
- With `MAIN_MEM_STATS_EN`: 3 reads and 2 writes give `rd_count`=3 and `wr_count`=2. Preload `wr_count`=16'hFFFF via force, do one more write: it wraps to 0.
